// File: rtl/canny_pkg.sv
// Shared constants and types for the Canny front end.
// Image geometry, bus widths and the window fetch state encoding.
package canny_pkg;

  localparam int NUM_ROWS = 520;
  localparam int NUM_COLS = 520;
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    VALID,
    DONE
  } wf_state_e;

endpackage

// File: rtl/window_fetch_raster.sv
// Raster position of the 3x3 window centre.
// Walks interior pixels only; border pixels never become centres.
module raster_counter
  import canny_pkg::*;
#(
  parameter int NUM_ROWS = canny_pkg::NUM_ROWS,
  parameter int NUM_COLS = canny_pkg::NUM_COLS
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              init_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] c_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 2);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NUM_COLS - 2);
  localparam logic [ADDR_W-1:0] C_START  = ADDR_W'(NUM_COLS + 1);
  localparam logic [ADDR_W-1:0] ROW_SKIP = ADDR_W'(3);

  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] c_q, c_d;

  // Next centre: restart on init, step right or wrap past the border.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    c_d   = c_q;
    if (init_i) begin
      row_d = ONE;
      col_d = ONE;
      c_d   = C_START;
    end else if (advance_i) begin
      if (col_q < LAST_COL) begin
        col_d = col_q + ONE;
        c_d   = c_q + ONE;
      end else begin
        col_d = ONE;
        row_d = row_q + ONE;
        c_d   = c_q + ROW_SKIP;
      end
    end
  end

  // Centre registers, parked on the first interior pixel in reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_q <= ONE;
      col_q <= ONE;
      c_q   <= C_START;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      c_q   <= c_d;
    end
  end

  assign c_o    = c_q;
  assign last_o = (row_q == LAST_ROW) && (col_q == LAST_COL);

endmodule

// File: rtl/window_fetch.sv
// 3x3 window fetcher: reads nine SRAMs per centre pixel
// and presents a registered window on a valid/ready port.
module window_fetch
  import canny_pkg::*;
#(
  parameter int NUM_ROWS = canny_pkg::NUM_ROWS,
  parameter int NUM_COLS = canny_pkg::NUM_COLS
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              read_enable_r,
  output logic [ADDR_W-1:0] add_a,
  output logic [ADDR_W-1:0] add_b,
  output logic [ADDR_W-1:0] add_c,
  output logic [ADDR_W-1:0] add_d,
  output logic [ADDR_W-1:0] add_e,
  output logic [ADDR_W-1:0] add_f,
  output logic [ADDR_W-1:0] add_g,
  output logic [ADDR_W-1:0] add_h,
  output logic [ADDR_W-1:0] add_i,
  input  logic [PIX_W-1:0]  read_a,
  input  logic [PIX_W-1:0]  read_b,
  input  logic [PIX_W-1:0]  read_c,
  input  logic [PIX_W-1:0]  read_d,
  input  logic [PIX_W-1:0]  read_e,
  input  logic [PIX_W-1:0]  read_f,
  input  logic [PIX_W-1:0]  read_g,
  input  logic [PIX_W-1:0]  read_h,
  input  logic [PIX_W-1:0]  read_i,
  output logic [PIX_W-1:0]  win_a,
  output logic [PIX_W-1:0]  win_b,
  output logic [PIX_W-1:0]  win_c,
  output logic [PIX_W-1:0]  win_d,
  output logic [PIX_W-1:0]  win_e,
  output logic [PIX_W-1:0]  win_f,
  output logic [PIX_W-1:0]  win_g,
  output logic [PIX_W-1:0]  win_h,
  output logic [PIX_W-1:0]  win_i,
  output logic [ADDR_W-1:0] win_addr,
  output logic              win_valid,
  input  logic              win_ready
);

  localparam logic [ADDR_W-1:0] W   = ADDR_W'(NUM_COLS);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  wf_state_e state_q, state_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic re_q, re_d;
  logic wv_q, wv_d;
  logic latch;

  logic [8:0][PIX_W-1:0] win_q;
  logic [8:0][PIX_W-1:0] rd;
  logic [ADDR_W-1:0]     waddr_q;
  logic [ADDR_W-1:0]     c;
  logic                  last;
  logic                  hs;
  logic                  init;
  logic                  adv;

  assign hs   = wv_q & win_ready;
  assign init = (state_q == IDLE) & start;
  assign adv  = hs & ~last;
  assign rd   = {read_i, read_h, read_g,
                 read_f, read_e, read_d,
                 read_c, read_b, read_a};

  raster_counter #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS)
  ) u_raster (
    .clk       (clk),
    .n_rst     (n_rst),
    .init_i    (init),
    .advance_i (adv),
    .c_o       (c),
    .last_o    (last)
  );

  // State register; reset abandons any pass in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: read, latch, then hold the window until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    state_d = LATCH;
      LATCH:   state_d = VALID;
      VALID:   if (hs) state_d = last ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, one cycle ahead of the registered outputs.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    err_d  = start & (state_q != IDLE) & (state_q != DONE);
    re_d   = (state_d == READ) | (state_d == LATCH);
    wv_d   = (state_d == VALID);
    latch  = (state_q == LATCH);
  end

  // Registered status and window outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      re_q    <= 1'b0;
      wv_q    <= 1'b0;
      win_q   <= '0;
      waddr_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      re_q   <= re_d;
      wv_q   <= wv_d;
      if (latch) begin
        win_q   <= rd;
        waddr_q <= c;
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign read_enable_r = re_q;
  assign win_valid     = wv_q;
  assign win_addr      = waddr_q;

  assign add_a = c - W - ONE;
  assign add_b = c - W;
  assign add_c = c - W + ONE;
  assign add_d = c - ONE;
  assign add_e = c;
  assign add_f = c + ONE;
  assign add_g = c + W - ONE;
  assign add_h = c + W;
  assign add_i = c + W + ONE;

  assign win_a = win_q[0];
  assign win_b = win_q[1];
  assign win_c = win_q[2];
  assign win_d = win_q[3];
  assign win_e = win_q[4];
  assign win_f = win_q[5];
  assign win_g = win_q[6];
  assign win_h = win_q[7];
  assign win_i = win_q[8];

endmodule

// File: tb/tb_window_fetch.sv
// Directed bench for window_fetch on a 5x5 image
// whose SRAM holds mem[k] = k.
module tb_window_fetch;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        busy, done, error, read_enable_r;
  logic [18:0] add_a, add_b, add_c, add_d, add_e;
  logic [18:0] add_f, add_g, add_h, add_i;
  logic [7:0]  read_a, read_b, read_c, read_d, read_e;
  logic [7:0]  read_f, read_g, read_h, read_i;
  logic [7:0]  win_a, win_b, win_c, win_d, win_e;
  logic [7:0]  win_f, win_g, win_h, win_i;
  logic [18:0] win_addr;
  logic        win_valid;
  logic        win_ready;

  window_fetch #(
    .NUM_ROWS (5),
    .NUM_COLS (5)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .read_enable_r (read_enable_r),
    .add_a (add_a), .add_b (add_b), .add_c (add_c),
    .add_d (add_d), .add_e (add_e), .add_f (add_f),
    .add_g (add_g), .add_h (add_h), .add_i (add_i),
    .read_a (read_a), .read_b (read_b), .read_c (read_c),
    .read_d (read_d), .read_e (read_e), .read_f (read_f),
    .read_g (read_g), .read_h (read_h), .read_i (read_i),
    .win_a (win_a), .win_b (win_b), .win_c (win_c),
    .win_d (win_d), .win_e (win_e), .win_f (win_f),
    .win_g (win_g), .win_h (win_h), .win_i (win_i),
    .win_addr  (win_addr),
    .win_valid (win_valid),
    .win_ready (win_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [32];
  initial for (int k = 0; k < 32; k++) mem[k] = 8'(k);

  always @(posedge clk) begin
    if (read_enable_r) begin
      read_a <= mem[add_a[4:0]];
      read_b <= mem[add_b[4:0]];
      read_c <= mem[add_c[4:0]];
      read_d <= mem[add_d[4:0]];
      read_e <= mem[add_e[4:0]];
      read_f <= mem[add_f[4:0]];
      read_g <= mem[add_g[4:0]];
      read_h <= mem[add_h[4:0]];
      read_i <= mem[add_i[4:0]];
    end
  end

  typedef struct {
    int stall;
    int centre;
  } vec_t;

  vec_t vecs [9];
  int   cent [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
  int   eadd [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

  int n_chk  = 0;
  int n_pass = 0;

  int got_q [$];
  int done_n, done_c, last_v, gap_bad;
  logic busy_after;

  logic [18:0] adds [9];
  assign adds = '{add_a, add_b, add_c, add_d, add_e,
                  add_f, add_g, add_h, add_i};

  function automatic logic [71:0] exp_win(input int c);
    return {8'(c - 6), 8'(c - 5), 8'(c - 4),
            8'(c - 1), 8'(c),     8'(c + 1),
            8'(c + 4), 8'(c + 5), 8'(c + 6)};
  endfunction

  function automatic logic [71:0] act_win();
    return {win_a, win_b, win_c, win_d, win_e,
            win_f, win_g, win_h, win_i};
  endfunction

  task automatic chk(input string nm,
                     input logic [71:0] act,
                     input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int k;
    for (k = 0; k < 20; k++) begin
      if (win_valid) break;
      cyc();
    end
    if (k == 20) chk({nm, "_timeout"}, 72'(win_valid), 72'd1);
  endtask

  task automatic run_free(input int max_cyc);
    win_ready = 1'b1;
    got_q.delete();
    done_n = 0;
    done_c = -10;
    last_v = -10;
    gap_bad = 0;
    busy_after = 1'bx;
    for (int k = 0; k < max_cyc; k++) begin
      if (win_valid) begin
        if (last_v >= 0 && k - last_v > 3) gap_bad++;
        got_q.push_back(int'(win_addr));
        last_v = k;
      end
      if (done_n > 0 && k == done_c + 1) begin
        busy_after = busy;
        break;
      end
      if (done) begin
        done_n++;
        done_c = k;
      end
      cyc();
    end
    win_ready = 1'b0;
  endtask

  task automatic check_pass(input string nm);
    chk({nm, "_count"}, 72'(got_q.size()), 72'd9);
    for (int i = 0; i < 9; i++) begin
      chk({nm, "_centre"},
          72'((i < got_q.size()) ? got_q[i] : -1),
          72'(cent[i]));
    end
    chk({nm, "_done_n"}, 72'(done_n), 72'd1);
    chk({nm, "_done_at"}, 72'(done_c - last_v), 72'd1);
    chk({nm, "_busy_after"}, 72'(busy_after), 72'd0);
    chk({nm, "_gap"}, 72'(gap_bad), 72'd0);
  endtask

  initial begin
    vecs[0] = '{10, 6};
    vecs[1] = '{0, 7};
    vecs[2] = '{2, 8};
    vecs[3] = '{0, 11};
    vecs[4] = '{1, 12};
    vecs[5] = '{0, 13};
    vecs[6] = '{0, 16};
    vecs[7] = '{3, 17};
    vecs[8] = '{0, 18};

    n_rst = 1'b0;
    start = 1'b0;
    win_ready = 1'b0;

    // reset held
    repeat (3) cyc();
    chk("rst_flags",
        72'({busy, done, error, win_valid, read_enable_r}), 72'd0);
    chk("rst_addr", 72'(win_addr), 72'd0);
    chk("rst_win", act_win(), 72'd0);

    // released, idle
    n_rst = 1'b1;
    repeat (3) cyc();
    chk("idle_flags",
        72'({busy, done, error, win_valid, read_enable_r}), 72'd0);
    chk("idle_win", act_win(), 72'd0);

    // pass 1: table of windows with stalls
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("read_busy_re", 72'({busy, read_enable_r}), 72'b11);
    for (int i = 0; i < 9; i++) chk("read_add", 72'(adds[i]), 72'(eadd[i]));

    for (int v = 0; v < 9; v++) begin
      wait_valid("vec_valid");
      chk("vec_addr", 72'(win_addr), 72'(vecs[v].centre));
      chk("vec_win", act_win(), exp_win(vecs[v].centre));
      for (int s = 0; s < vecs[v].stall; s++) begin
        cyc();
        chk("stall_vld_re", 72'({win_valid, read_enable_r}), 72'b10);
        chk("stall_addr", 72'(win_addr), 72'(vecs[v].centre));
        chk("stall_win", act_win(), exp_win(vecs[v].centre));
      end
      win_ready = 1'b1;
      cyc();
      win_ready = 1'b0;
    end
    chk("p1_done", 72'({done, busy}), 72'b11);
    cyc();
    chk("p1_idle", 72'({done, busy, win_valid}), 72'b000);

    // pass 2: ready tied high
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_free(60);
    check_pass("free");

    // pass 3: start during VALID flags error only
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_valid("err_valid");
    chk("err_first", 72'(win_addr), 72'd6);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("err_hi", 72'({error, win_valid}), 72'b11);
    chk("err_addr", 72'(win_addr), 72'd6);
    cyc();
    chk("err_lo", 72'(error), 72'd0);
    run_free(60);
    check_pass("err");

    // pass 4: reset during the 4th window
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    win_ready = 1'b1;
    begin
      int nv = 0;
      for (int k = 0; k < 60; k++) begin
        if (win_valid) nv++;
        if (nv == 4) break;
        cyc();
      end
      chk("mid_nv", 72'(nv), 72'd4);
    end
    chk("mid_addr", 72'(win_addr), 72'd11);
    n_rst = 1'b0;
    cyc();
    chk("mid_rst_flags",
        72'({busy, done, error, win_valid, read_enable_r}), 72'd0);
    chk("mid_rst_addr", 72'(win_addr), 72'd0);
    n_rst = 1'b1;
    win_ready = 1'b0;
    cyc();
    chk("mid_idle", 72'({busy, win_valid}), 72'b00);
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_free(60);
    check_pass("restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/window_fetch.md
WINDOW_FETCH -- requirements
Module: window_fetch

Interface
REQ-001 Parameter NUM_ROWS, default 520, image height in pixels.
REQ-002 Parameter NUM_COLS, default 520, image width in pixels.
REQ-003 Port clk  in  1  system clock; one clock, all state on rising edge.
REQ-004 Port n_rst  in  1  reset, asynchronous and active-low.
REQ-005 Port start  in  1  level, sampled in IDLE; begins one full-image pass.
REQ-006 Port busy  out  1  high from the cycle after start is accepted until DONE exits.
REQ-007 Port done  out  1  one-cycle pulse when the last window is handed off.
REQ-008 Port error  out  1  one-cycle pulse when start is high in any state other than IDLE or DONE.
REQ-009 Port read_enable_r  out  1  read enable shared by all nine read SRAMs.
REQ-010 Ports add_a..add_i  out  19 each  read SRAM addresses of the 3x3 window, raster order a=top-left .. i=bottom-right.
REQ-011 Ports read_a..read_i  in  8 each  read SRAM data, valid the cycle after address with read_enable_r high.
REQ-012 Ports win_a..win_i  out  8 each  registered 3x3 pixel window.
REQ-013 Port win_addr  out  19  linear address of the centre pixel (row*NUM_COLS+col).
REQ-014 Port win_valid  out  1  window and win_addr valid.
REQ-015 Port win_ready  in  1  downstream accepts; transfer when win_valid and win_ready are both high on a rising edge.

Function
REQ-016 FSM states: IDLE, READ, LATCH, VALID, DONE.
REQ-017 IDLE: start=1 -> READ. Centre is initialised to row=1, col=1, centre address NUM_COLS+1.
REQ-018 READ, one cycle: read_enable_r=1 and addresses driven from the registered centre address C; -> LATCH.
REQ-019 Address map: a=C-W-1, b=C-W, c=C-W+1, d=C-1, e=C, f=C+1, g=C+W-1, h=C+W, i=C+W+1, where W=NUM_COLS. All values are 19-bit unsigned, with no wrap for legal parameters.
REQ-020 LATCH, one cycle: read_enable_r=1 and addresses held; read_a..read_i are registered into win_a..win_i at the end of the cycle; win_addr<=C; -> VALID.
REQ-021 VALID: win_valid=1, with win_* and win_addr stable and read_enable_r=0 until the handshake.
REQ-022 VALID with the handshake at the last centre -> DONE; otherwise -> READ. The cycle in which win_valid first rises may complete the handshake.
REQ-023 Centre advance on handshake:
- if col<NUM_COLS-2: col+1, C+1;
- else: col=1, row+1, C+3.
REQ-024 The last centre is row=NUM_ROWS-2, col=NUM_COLS-2. A pass yields exactly (NUM_ROWS-2)*(NUM_COLS-2) windows; border pixels never become centres.
REQ-025 DONE, one cycle: done=1; -> IDLE. Counters are not cleared until the next start.
REQ-026 The error pulse never alters the FSM or counters. A start held through DONE is ignored in DONE and is accepted in the following IDLE.
REQ-027 Minimum throughput: one window per 3 cycles with win_ready held high.
REQ-028 Address ports hold their last value outside READ/LATCH. All outputs are registered except add_a..add_i, which are decoded from registered C.

Reset
REQ-029 n_rst low forces IDLE at once, including mid-pass; the partial pass is abandoned.
REQ-030 Values held while n_rst is low:
- busy, done, error, win_valid and read_enable_r: 0;
- win_a..win_i and win_addr: 0;
- row and col: 1;
- C: NUM_COLS+1.

Structure
REQ-031 Shared package canny_pkg holds NUM_ROWS, NUM_COLS, ADDR_W=19, PIX_W=8 and the window_fetch state enum.
REQ-032 One sub-module, raster_counter, holds row, col and C. It takes advance and init inputs and produces a last flag.

Verification
REQ-033 All scenarios use NUM_ROWS=5 and NUM_COLS=5, with SRAM contents mem[k]=k.
REQ-034 Reset held, then released with start=0 -> all outputs 0; state remains IDLE.
REQ-035 start pulse -> READ drives add_a..add_i = 0,1,2,5,6,7,10,11,12; at the first win_valid, win_a..win_i equal those values and win_addr=6.
REQ-036 win_ready low for 10 cycles in VALID -> win_valid stays 1; win_* and win_addr do not change; read_enable_r=0.
REQ-037 Handshake at win_addr=8 (row 1, col 3) -> next window has win_addr=11 and win_e=11.
REQ-038 win_ready tied high -> exactly 9 windows, centres 6,7,8,11,12,13,16,17,18; done pulses once one cycle after the last handshake; busy then drops.
REQ-039 start in VALID -> error pulses for exactly 1 cycle and the window sequence is unchanged.
REQ-040 n_rst low during the 4th window -> IDLE; a new start restarts at win_addr=6.
